// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with parametrised fetch and data-memory latency.
// Optional build macro CTRL_PERF_EN adds cycle_cnt/instr_cnt performance counters.
module mc_ctrl #(
    parameter int IF_LAT  = 1,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             nop_in,
    input  logic             zero,
    input  logic             bgez,
`ifdef CTRL_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
`endif
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       rd_sel,
    output logic [1:0]       grf_sel,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             ext_type,
    output logic             mem_write,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUBU   = 6'h23;
    localparam logic [5:0] FN_SLT    = 6'h2A;

    localparam int MAX_LAT = (IF_LAT > MEM_LAT) ? IF_LAT : MEM_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t        state_q;
    logic [CW-1:0] wcnt;

    logic is_r, is_addu, is_subu, is_slt, is_jr, is_ori, is_sltiu;
    logic is_lw, is_sw, is_beq, is_bgez, is_jal;
    logic alu_r, legal, to_wb, to_mem, if_last, mem_last;

    assign is_r     = (op == OP_RTYPE);
    assign is_addu  = is_r && (funct == FN_ADDU);
    assign is_subu  = is_r && (funct == FN_SUBU);
    assign is_slt   = is_r && (funct == FN_SLT);
    assign is_jr    = is_r && (funct == FN_JR);
    assign is_ori   = (op == OP_ORI);
    assign is_sltiu = (op == OP_SLTIU);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_bgez  = (op == OP_REGIMM);
    assign is_jal   = (op == OP_JAL);

    assign alu_r    = is_addu || is_subu || is_slt;
    assign legal    = alu_r || is_jr || is_ori || is_sltiu || is_lw || is_sw ||
                      is_beq || is_bgez || is_jal;
    assign to_wb    = alu_r || is_ori || is_sltiu;
    assign to_mem   = is_lw || is_sw;
    assign if_last  = (wcnt == CW'(IF_LAT - 1));
    assign mem_last = (wcnt == CW'(MEM_LAT - 1));
    assign state    = state_q;

    // The wait counter is only non-zero inside FETCH and MEM; every exit clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            wcnt    <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (if_last) begin
                        state_q <= DECODE;
                        wcnt    <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DECODE: begin
                    wcnt    <= '0;
                    state_q <= (nop_in || !legal) ? FETCH : EXEC;
                end
                EXEC: begin
                    wcnt    <= '0;
                    state_q <= to_mem ? MEM : (to_wb ? WB : FETCH);
                end
                MEM: begin
                    if (mem_last) begin
                        state_q <= is_sw ? FETCH : WB;
                        wcnt    <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: begin
                    state_q <= FETCH;
                    wcnt    <= '0;
                end
            endcase
        end
    end

    // Outputs are gated by reset so nothing is enabled while it is held.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        rd_sel     = 2'd0;
        grf_sel    = 2'd0;
        alu_src    = 1'b0;
        alu_op     = 3'd0;
        ext_type   = 1'b0;
        mem_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            if (state_q == EXEC || state_q == MEM || state_q == WB) begin
                alu_src  = is_ori || is_sltiu || is_lw || is_sw;
                ext_type = is_sltiu || is_lw || is_sw;
                if (is_subu || is_beq) alu_op = 3'd1;
                else if (is_ori)       alu_op = 3'd2;
                else if (is_slt)       alu_op = 3'd3;
                else if (is_sltiu)     alu_op = 3'd4;
            end
            case (state_q)
                FETCH: begin
                    ir_write = if_last;
                    pc_write = if_last;
                end
                DECODE: begin
                    illegal    = !nop_in && !legal;
                    instr_done = nop_in || !legal;
                end
                EXEC: begin
                    instr_done = !to_mem && !to_wb;
                    if (is_beq) begin
                        pc_src   = 2'd1;
                        pc_write = zero;
                    end else if (is_bgez) begin
                        pc_src   = 2'd1;
                        pc_write = bgez;
                    end else if (is_jal) begin
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                        reg_write = 1'b1;
                        rd_sel    = 2'd2;
                        grf_sel   = 2'd3;
                    end else if (is_jr) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd3;
                    end
                end
                MEM: begin
                    mem_write  = mem_last && is_sw;
                    instr_done = mem_last && is_sw;
                end
                WB: begin
                    reg_write  = 1'b1;
                    rd_sel     = is_r ? 2'd0 : 2'd1;
                    grf_sel    = is_lw ? 2'd2 : 2'd0;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (instr_done) instr_cnt <= instr_cnt + 1'b1;
        end
    end
`endif

endmodule
